// File: rtl/cc_fill_deserializer.sv
// Miss-path fill deserializer: collects a critical-word-first wrap burst from the R channel,
// rebuilds it in line order and offers the line plus its aligned address to the cache fill port.
module cc_fill_deserializer #(
  parameter int ADDR_WIDTH = 32,
  parameter int BEAT_WIDTH = 64,
  parameter int BEATS      = 8,
  parameter int REQ_DEPTH  = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid_i,
  input  logic [ADDR_WIDTH-1:0]       req_addr_i,
  output logic                        req_full_o,
  input  logic [BEAT_WIDTH-1:0]       mem_rdata_i,
  input  logic                        mem_rlast_i,
  input  logic                        mem_rvalid_i,
  output logic                        mem_rready_o,
  output logic                        fill_valid_o,
  input  logic                        fill_ready_i,
  output logic [ADDR_WIDTH-1:0]       fill_addr_o,
  output logic [BEAT_WIDTH*BEATS-1:0] fill_data_o,
  output logic                        rlast_err_o
);

  localparam int LINE_W   = BEAT_WIDTH * BEATS;
  localparam int WI_W     = $clog2(BEATS);
  localparam int BEAT_OFF = $clog2(BEAT_WIDTH / 8);
  localparam int LINE_OFF = BEAT_OFF + WI_W;
  localparam int PTR_W    = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int CNT_W    = $clog2(REQ_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   fifo_q [REQ_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    full_q;
  logic [WI_W-1:0]         wi_q;
  logic [WI_W-1:0]         bc_q;
  logic [ADDR_WIDTH-1:0]   fill_addr_q;
  logic [LINE_W-1:0]       fill_data_q;
  logic                    rlast_err_q;

  logic                    fifo_empty;
  logic                    push, pop;
  logic                    beat_fire, last_beat, burst_end;
  logic [ADDR_WIDTH-1:0]   head_addr;
  logic [ADDR_WIDTH-1:0]   head_line_addr;
  logic [WI_W-1:0]         head_wi;
  logic                    unused_addr_bits;

  assign fifo_empty     = (count_q == '0);
  assign head_addr      = fifo_q[rd_ptr_q];
  assign head_line_addr = {head_addr[ADDR_WIDTH-1:LINE_OFF], {LINE_OFF{1'b0}}};
  assign head_wi        = head_addr[LINE_OFF-1:BEAT_OFF];
  assign unused_addr_bits = ^head_addr[BEAT_OFF-1:0];

  assign beat_fire = (state_q == COLLECT) && mem_rvalid_i;
  assign last_beat = (bc_q == WI_W'(BEATS - 1));
  assign burst_end = mem_rlast_i || last_beat;
  assign pop       = beat_fire && burst_end;
  // A full FIFO can still take a push in the same cycle the head is retired.
  assign push      = req_valid_i && (!full_q || pop);

  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(REQ_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= req_addr_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ptrInc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptrInc(rd_ptr_q);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(REQ_DEPTH));
    end
  end

  // Beats land directly in the output line register, so words a short burst never reaches keep their old value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wi_q        <= '0;
      bc_q        <= '0;
      fill_addr_q <= '0;
      fill_data_q <= '0;
      rlast_err_q <= 1'b0;
    end else begin
      rlast_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q     <= COLLECT;
            fill_addr_q <= head_line_addr;
            wi_q        <= head_wi;
            bc_q        <= '0;
          end
        end
        COLLECT: begin
          if (mem_rvalid_i) begin
            for (int w = 0; w < BEATS; w++) begin
              if (wi_q == WI_W'(w)) fill_data_q[w*BEAT_WIDTH +: BEAT_WIDTH] <= mem_rdata_i;
            end
            wi_q <= wi_q + WI_W'(1);
            bc_q <= bc_q + WI_W'(1);
            if (burst_end) begin
              state_q     <= OUTPUT;
              rlast_err_q <= mem_rlast_i ^ last_beat;
            end
          end
        end
        OUTPUT: begin
          if (fill_ready_i) begin
            if (!fifo_empty) begin
              state_q     <= COLLECT;
              fill_addr_q <= head_line_addr;
              wi_q        <= head_wi;
              bc_q        <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_rready_o = (state_q == COLLECT);
  assign fill_valid_o = (state_q == OUTPUT);
  assign req_full_o   = full_q;
  assign fill_addr_o  = fill_addr_q;
  assign fill_data_o  = fill_data_q;
  assign rlast_err_o  = rlast_err_q;

endmodule

// File: doc/cc_fill_deserializer.md
Name: cc_fill_deserializer

Overview:
- Receive side of the miss path: accepts wrap-burst read data (critical word first) from memory on the AXI R channel and rebuilds it into one line-ordered 512-bit cache line.
- Presents the rebuilt line and its line-aligned address to the cache data/tag array fill port using a valid/ready handshake.
- Miss addresses are queued in an internal request FIFO, in AR issue order, so several misses can be outstanding.

Parameters:
ADDR_WIDTH, 32, byte address width
BEAT_WIDTH, 64, R-channel data width in bits
BEATS, 8, beats per line; line width = BEAT_WIDTH*BEATS = 512
REQ_DEPTH, 2, depth of the outstanding-miss address FIFO (power of 2)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous, active-low reset
req_valid_i  input  1  miss address push, one per AR issued
req_addr_i  input  ADDR_WIDTH  miss byte address; bits [5:3] are the critical word index
req_full_o  output  1  request FIFO full; when high, the requester must not assert req_valid_i
mem_rdata_i  input  BEAT_WIDTH  R data
mem_rlast_i  input  1  R last
mem_rvalid_i  input  1  R valid
mem_rready_o  output  1  R ready
fill_valid_o  output  1  assembled line valid
fill_ready_i  input  1  fill port ready
fill_addr_o  output  ADDR_WIDTH  line-aligned address, bits [5:0] = 0
fill_data_o  output  512  line data; word w sits at bits [64w+63:64w]
rlast_err_o  output  1  one-cycle pulse on an rlast/beat-count mismatch

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - request FIFO empty; FSM in IDLE; beat counter = 0.
  - mem_rready_o=0, fill_valid_o=0, rlast_err_o=0, req_full_o=0; fill_data_o/fill_addr_o = 0.
  - Reset mid-burst drops all partial state. Any remaining beats must be discarded by the system, since rready stays 0 until the next request is queued.
- Request FIFO:
  - Pushes on req_valid_i & !req_full_o.
  - A push while full is ignored and holds the count.
  - Simultaneous push and pop is allowed when full.
  - Pop happens in COLLECT on the accepted beat that terminates the burst.
- FSM states and transitions:
  - IDLE:
    - mem_rready_o=0.
    - If the FIFO is non-empty, go to COLLECT next cycle.
    - Latch the head address as base; set word index wi = base[5:3]; clear beat counter bc.
  - COLLECT:
    - mem_rready_o=1.
    - On mem_rvalid_i & mem_rready_o: write the beat into line word wi; wi = wi+1 mod 8 (wrap); bc = bc+1.
    - The burst ends on either the accepted beat with mem_rlast_i=1, or the 8th beat (bc==7).
    - At burst end: pop the FIFO, go to OUTPUT next cycle.
    - If rlast arrives with bc!=7, or bc==7 arrives without rlast: pulse rlast_err_o for 1 cycle and still go to OUTPUT. Missing words keep their previous contents.
  - OUTPUT:
    - fill_valid_o=1; mem_rready_o=0.
    - fill_addr_o = {base[ADDR-1:6],6'b0} and fill_data_o are stable while valid and not ready.
    - On fill_valid_o & fill_ready_i: if the FIFO is non-empty, go to COLLECT directly, re-latching base from the head; otherwise go to IDLE.
- Timing:
  - Latency from last-beat acceptance to fill_valid_o is 1 cycle.
  - Back-to-back misses incur 1 bubble cycle: the OUTPUT handshake, then COLLECT.
- All outputs are registered except mem_rready_o and fill_valid_o, which are decoded from the FSM state register.
- Beats arriving while mem_rready_o=0 are not consumed. Holding them is the AXI responsibility of the sender.

Test Plan:
- Aligned fill:
  - Stimulus: push addr 0x0000_1000; 8 beats with data 0x0..0x7, rlast on beat 8; fill_ready_i=1.
  - Required: fill_valid_o high 1 cycle after the last beat; fill_addr_o=0x1000; word w = w; rlast_err_o never asserted.
- Wrapped fill:
  - Stimulus: push addr 0x0000_2028 (critical word 5); beats 0xA0..0xA7.
  - Required: words 5,6,7,0,1,2,3,4 hold 0xA0..0xA7 in that order; fill_addr_o=0x2000.
- Backpressure:
  - Stimulus: fill_ready_i=0 for 5 cycles after valid; a second request is queued with its R beats already pending.
  - Required: fill_valid_o, fill_addr_o and fill_data_o hold steady; mem_rready_o=0 throughout the stall; the second line is collected correctly after the handshake.
- Request FIFO full:
  - Stimulus: push 3 addresses with no R traffic.
  - Required: req_full_o=1 after 2 pushes; the 3rd push is ignored; both queued lines fill in push order.
- rlast errors:
  - Stimulus: early rlast on beat 6; in a separate run, 8 beats with no rlast.
  - Required: rlast_err_o pulses exactly 1 cycle; OUTPUT is still entered; for the early case, words 6 and 7 are unchanged.
- Reset mid-burst:
  - Stimulus: assert rst_n=0 after beat 3, then push a new request.
  - Required: all outputs return to reset values; the next line fills cleanly with no stale words from the aborted burst.
